// File: rtl/multi_cyc_impl_checker.sv
// Implication checker: an antecedent sampled at edge k is judged against the
// consequent sampled DELAY edges later; results pulse and feed saturating counters.
module multi_cyc_impl_checker #(
  parameter int DELAY = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             disable_i,
  input  logic             ant_i,
  input  logic             cons_i,
  input  logic             clr_cnt_i,
  output logic             pass_o,
  output logic             fail_o,
  output logic             fail_seen_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic             busy_o
);

  logic [DELAY-1:0] pend_q, pend_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             fail_seen_q, fail_seen_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             mature;

  // Bit i set means an attempt started i+1 edges ago; disable flushes them all.
  always_comb begin
    pend_d = '0;
    if (!disable_i) begin
      pend_d[0] = en_i && ant_i;
      for (int i = 1; i < DELAY; i++) begin
        pend_d[i] = pend_q[i-1];
      end
    end
  end

  assign mature = pend_q[DELAY-1] && !disable_i;

  always_comb begin
    pass_d      = mature && cons_i;
    fail_d      = mature && !cons_i;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_seen_d = fail_seen_q;
    if (clr_cnt_i) begin
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      fail_seen_d = 1'b0;
    end else begin
      if (pass_d && (pass_cnt_q != {CNT_W{1'b1}})) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      if (fail_d && (fail_cnt_q != {CNT_W{1'b1}})) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      if (fail_d) fail_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_seen_q <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_seen_q <= fail_seen_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign fail_seen_o = fail_seen_q;
  assign pass_cnt_o  = pass_cnt_q;
  assign fail_cnt_o  = fail_cnt_q;
  assign busy_o      = |pend_q;

endmodule

// File: tb/tb_multi_cyc_impl_checker.sv
// Bench for multi_cyc_impl_checker: three instances (DELAY 2/3/1) share stimulus
// and are compared every cycle against an attempt-history reference model.
module tb_multi_cyc_impl_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, en_i = 1'b0, disable_i = 1'b0;
  logic ant_i = 1'b0, cons_i = 1'b0, clr_cnt_i = 1'b0;

  logic        p0, f0, s0, b0, p1, f1, s1, b1, p2, f2, s2, b2;
  logic [15:0] pc0, fc0, pc2, fc2;
  logic [1:0]  pc1, fc1;

  multi_cyc_impl_checker #(.DELAY(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .disable_i(disable_i), .ant_i(ant_i),
    .cons_i(cons_i), .clr_cnt_i(clr_cnt_i), .pass_o(p0), .fail_o(f0),
    .fail_seen_o(s0), .pass_cnt_o(pc0), .fail_cnt_o(fc0), .busy_o(b0));

  multi_cyc_impl_checker #(.DELAY(3), .CNT_W(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .disable_i(disable_i), .ant_i(ant_i),
    .cons_i(cons_i), .clr_cnt_i(clr_cnt_i), .pass_o(p1), .fail_o(f1),
    .fail_seen_o(s1), .pass_cnt_o(pc1), .fail_cnt_o(fc1), .busy_o(b1));

  multi_cyc_impl_checker #(.DELAY(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .disable_i(disable_i), .ant_i(ant_i),
    .cons_i(cons_i), .clr_cnt_i(clr_cnt_i), .pass_o(p2), .fail_o(f2),
    .fail_seen_o(s2), .pass_cnt_o(pc2), .fail_cnt_o(fc2), .busy_o(b2));

  // ---------------- reference model ----------------
  localparam int NE = 4096;
  localparam int OW = 36;
  int dly[3]  = '{2, 3, 1};
  int maxc[3] = '{65535, 3, 65535};
  bit started[3][NE];
  int last_kill[3];
  bit m_pass[3], m_fail[3], m_seen[3], m_busy[3];
  int m_pc[3], m_fc[3];
  int t = 0;

  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [OW-1:0] pk(logic p, logic f, logic s, logic b,
                                       logic [15:0] pc, logic [15:0] fc);
    return {p, f, s, b, pc, fc};
  endfunction

  // An attempt started at edge s reports at s+d unless a reset or disable hit any edge in (s, s+d].
  task automatic model_edge(input int i);
    int d;
    bit mat;
    d = dly[i];
    if (!rst_n) begin
      started[i][t] = 1'b0;
      last_kill[i]  = t;
      m_pass[i] = 0; m_fail[i] = 0; m_seen[i] = 0; m_pc[i] = 0; m_fc[i] = 0;
    end else begin
      mat = (t - d >= 0) && started[i][t-d] && (last_kill[i] <= t - d) && !disable_i;
      started[i][t] = en_i && ant_i && !disable_i;
      if (disable_i) last_kill[i] = t;
      m_pass[i] = mat && cons_i;
      m_fail[i] = mat && !cons_i;
      if (clr_cnt_i) begin
        m_pc[i] = 0; m_fc[i] = 0; m_seen[i] = 0;
      end else begin
        if (m_pass[i] && m_pc[i] < maxc[i]) m_pc[i]++;
        if (m_fail[i] && m_fc[i] < maxc[i]) m_fc[i]++;
        if (m_fail[i]) m_seen[i] = 1;
      end
    end
    m_busy[i] = 0;
    for (int s = t - d + 1; s <= t; s++)
      if (s >= 0 && started[i][s] && s > last_kill[i]) m_busy[i] = 1;
    exp_q.push_back(pk(m_pass[i], m_fail[i], m_seen[i], m_busy[i], 16'(m_pc[i]), 16'(m_fc[i])));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got p%0b f%0b s%0b b%0b pc%0d fc%0d expected p%0b f%0b s%0b b%0b pc%0d fc%0d",
               name, t, act[35], act[34], act[33], act[32], act[31:16], act[15:0],
               exp[35], exp[34], exp[33], exp[32], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0b expected %0b", name, t, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] act_of(input int i);
    case (i)
      0:       return pk(p0, f0, s0, b0, pc0, fc0);
      1:       return pk(p1, f1, s1, b1, {14'b0, pc1}, {14'b0, fc1});
      default: return pk(p2, f2, s2, b2, pc2, fc2);
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit e, input bit d, input bit a, input bit c, input bit k);
    logic [OW-1:0] exp;
    rst_n = r; en_i = e; disable_i = d; ant_i = a; cons_i = c; clr_cnt_i = k;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    t++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      check($sformatf("model_d%0d", dly[i]), act_of(i), exp);
    end
  endtask

  // ---------------- directed table (DELAY=2 instance) ----------------
  typedef struct {
    bit r, e, d, a, c, k;
    bit ep, ef, es, eb;
    int epc, efc;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl[NV];

  function automatic vec_t mk(bit r, bit e, bit d, bit a, bit c, bit k,
                              bit ep, bit ef, bit es, bit eb, int epc, int efc);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.a = a; v.c = c; v.k = k;
    v.ep = ep; v.ef = ef; v.es = es; v.eb = eb; v.epc = epc; v.efc = efc;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) last_kill[i] = -1;
    //           r e d a c k   p f s b pc fc
    tbl[0]  = mk(0,0,0,0,0,0,  0,0,0,0, 0, 0);
    tbl[1]  = mk(0,1,0,1,1,0,  0,0,0,0, 0, 0);
    tbl[2]  = mk(1,1,0,1,0,0,  0,0,0,1, 0, 0);  // single attempt
    tbl[3]  = mk(1,1,0,0,0,0,  0,0,0,1, 0, 0);
    tbl[4]  = mk(1,1,0,0,1,0,  1,0,0,0, 1, 0);
    tbl[5]  = mk(1,1,0,0,0,0,  0,0,0,0, 1, 0);
    tbl[6]  = mk(1,1,0,0,0,1,  0,0,0,0, 0, 0);
    tbl[7]  = mk(1,1,0,1,0,0,  0,0,0,1, 0, 0);  // overlapping pair
    tbl[8]  = mk(1,1,0,1,0,0,  0,0,0,1, 0, 0);
    tbl[9]  = mk(1,1,0,0,1,0,  1,0,0,1, 1, 0);
    tbl[10] = mk(1,1,0,0,0,0,  0,1,1,0, 1, 1);
    tbl[11] = mk(1,1,0,0,0,0,  0,0,1,0, 1, 1);
    tbl[12] = mk(1,0,0,1,0,0,  0,0,1,0, 1, 1);  // en low
    tbl[13] = mk(1,0,0,1,0,0,  0,0,1,0, 1, 1);
    tbl[14] = mk(1,1,0,0,0,0,  0,0,1,0, 1, 1);
    tbl[15] = mk(1,1,0,1,1,0,  0,0,1,1, 1, 1);  // disable mid-attempt
    tbl[16] = mk(1,1,1,0,1,0,  0,0,1,0, 1, 1);
    tbl[17] = mk(1,1,0,0,1,0,  0,0,1,0, 1, 1);
    tbl[18] = mk(1,1,0,1,0,0,  0,0,1,1, 1, 1);  // clear coincident with fail
    tbl[19] = mk(1,1,0,0,0,0,  0,0,1,1, 1, 1);
    tbl[20] = mk(1,1,0,0,0,1,  0,1,0,0, 0, 0);
    tbl[21] = mk(1,1,0,0,0,0,  0,0,0,0, 0, 0);
    tbl[22] = mk(1,1,0,1,0,0,  0,0,0,1, 0, 0);  // reset mid-attempt
    tbl[23] = mk(0,1,0,0,0,0,  0,0,0,0, 0, 0);
    tbl[24] = mk(1,1,0,0,1,0,  0,0,0,0, 0, 0);
    tbl[25] = mk(1,1,0,0,0,0,  0,0,0,0, 0, 0);
    tbl[26] = mk(1,1,0,1,0,0,  0,0,0,1, 0, 0);  // disable on the maturing edge
    tbl[27] = mk(1,1,0,0,0,0,  0,0,0,1, 0, 0);
    tbl[28] = mk(1,1,1,1,1,0,  0,0,0,0, 0, 0);
    tbl[29] = mk(1,1,0,0,0,0,  0,0,0,0, 0, 0);

    for (int v = 0; v < NV; v++) begin
      step(tbl[v].r, tbl[v].e, tbl[v].d, tbl[v].a, tbl[v].c, tbl[v].k);
      check($sformatf("table_row%0d", v), act_of(0),
            pk(tbl[v].ep, tbl[v].ef, tbl[v].es, tbl[v].eb, 16'(tbl[v].epc), 16'(tbl[v].efc)));
    end

    // DELAY=3: disable two edges after the antecedent kills the attempt
    step(1,1,0,1,0,0);
    step(1,1,0,0,0,0);
    step(1,1,1,0,0,0);
    check_bit("d3_disable_busy", b1, 1'b0);
    step(1,1,0,0,1,0);
    check_bit("d3_disable_no_pass", p1, 1'b0);
    check_bit("d3_disable_no_fail", f1, 1'b0);

    // CNT_W=2: five failures saturate at 3, then a clear beats a coincident fail
    step(1,1,0,0,0,1);
    for (int n = 0; n < 5; n++) step(1,1,0,1,0,0);
    for (int n = 0; n < 3; n++) step(1,1,0,0,0,0);
    check_bit("sat_fail_cnt", fc1 == 2'd3, 1'b1);
    check_bit("sat_fail_seen", s1, 1'b1);
    step(1,1,0,1,0,0);
    step(1,1,0,0,0,0);
    step(1,1,0,0,0,0);
    step(1,1,0,0,0,1);
    check_bit("clr_fail_pulse", f1, 1'b1);
    check_bit("clr_fail_cnt", fc1 == 2'd0, 1'b1);
    check_bit("clr_fail_seen", s1, 1'b0);

    // DELAY=1: antecedent with en low never starts an attempt
    step(1,1,0,0,0,0);
    for (int n = 0; n < 4; n++) begin
      step(1,0,0,1,0,0);
      check_bit("d1_en_low_fail", f2, 1'b0);
      check_bit("d1_en_low_busy", b2, 1'b0);
    end

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
